// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : Execute stage of the 5-stage pipelined MIPS core. Resolves RAW
//             hazards by forwarding from EX/MEM and MEM/WB, computes the ALU
//             result and registers it together with the control bits into
//             the EX/MEM pipeline register (stall / flush aware).
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             stall, flush              - EX/MEM hold / bubble insertion
//             id_*                      - decoded instruction from ID/EX
//             wb_reg_write/wb_rd/wb_result - MEM/WB forwarding source
//             ex_mem_*                  - registered EX/MEM contents
//             branch_taken              - registered valid & branch & zero
//  Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [3:0]            id_alu_ctrl,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_alu_src,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_result,
  output logic                  ex_mem_valid,
  output logic [DATA_W-1:0]     ex_mem_result,
  output logic [DATA_W-1:0]     ex_mem_store,
  output logic [REG_ADDR_W-1:0] ex_mem_rd,
  output logic                  ex_mem_reg_write,
  output logic                  ex_mem_mem_read,
  output logic                  ex_mem_mem_write,
  output logic                  ex_mem_zero,
  output logic                  branch_taken
);

  localparam logic [3:0] c_alu_add = 4'b0000;
  localparam logic [3:0] c_alu_sub = 4'b0001;
  localparam logic [3:0] c_alu_and = 4'b0010;
  localparam logic [3:0] c_alu_or  = 4'b0011;
  localparam logic [3:0] c_alu_slt = 4'b0100;

  // EX/MEM pipeline register
  logic                  r_valid;
  logic [DATA_W-1:0]     r_result;
  logic [DATA_W-1:0]     r_store;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_zero;
  logic                  r_branch_taken;

  logic                  w_exm_src_ok;
  logic                  w_wb_src_ok;
  logic [DATA_W-1:0]     w_fwd_rs;
  logic [DATA_W-1:0]     w_fwd_rt;
  logic [DATA_W-1:0]     w_op_a;
  logic [DATA_W-1:0]     w_op_b;
  logic [DATA_W-1:0]     w_result;
  logic                  w_slt;
  logic                  w_zero;

  // A pending load in EX/MEM has no data yet (its result is the address), so
  // it is excluded; load-use is stalled upstream. Register 0 is never a source.
  assign w_exm_src_ok = r_reg_write & ~r_mem_read & (r_rd != '0);
  assign w_wb_src_ok  = wb_reg_write & (wb_rd != '0);

  always_comb begin
    w_fwd_rs = id_rs_data;
    if (w_exm_src_ok && (r_rd == id_rs)) begin
      w_fwd_rs = r_result;
    end else if (w_wb_src_ok && (wb_rd == id_rs)) begin
      w_fwd_rs = wb_result;
    end
  end

  always_comb begin
    w_fwd_rt = id_rt_data;
    if (w_exm_src_ok && (r_rd == id_rt)) begin
      w_fwd_rt = r_result;
    end else if (w_wb_src_ok && (wb_rd == id_rt)) begin
      w_fwd_rt = wb_result;
    end
  end

  assign w_op_a = w_fwd_rs;
  assign w_op_b = id_alu_src ? id_imm : w_fwd_rt;
  assign w_slt  = ($signed(w_op_a) < $signed(w_op_b));

  always_comb begin
    w_result = '0;
    case (id_alu_ctrl)
      c_alu_add: w_result = w_op_a + w_op_b;
      c_alu_sub: w_result = w_op_a - w_op_b;
      c_alu_and: w_result = w_op_a & w_op_b;
      c_alu_or:  w_result = w_op_a | w_op_b;
      c_alu_slt: w_result = {{(DATA_W-1){1'b0}}, w_slt};
      default:   w_result = '0;
    endcase
  end

  assign w_zero = (w_result == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_result       <= '0;
      r_store        <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_zero         <= 1'b0;
      r_branch_taken <= 1'b0;
    end else if (flush) begin
      // Data fields are left untouched; only the side-effect controls drop.
      r_valid        <= 1'b0;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_branch_taken <= 1'b0;
    end else if (!stall) begin
      r_valid        <= id_valid;
      r_result       <= w_result;
      r_store        <= w_fwd_rt;
      r_rd           <= id_rd;
      r_reg_write    <= id_valid & id_reg_write;
      r_mem_read     <= id_valid & id_mem_read;
      r_mem_write    <= id_valid & id_mem_write;
      r_zero         <= w_zero;
      r_branch_taken <= id_valid & id_branch & w_zero;
    end
  end

  assign ex_mem_valid     = r_valid;
  assign ex_mem_result    = r_result;
  assign ex_mem_store     = r_store;
  assign ex_mem_rd        = r_rd;
  assign ex_mem_reg_write = r_reg_write;
  assign ex_mem_mem_read  = r_mem_read;
  assign ex_mem_mem_write = r_mem_write;
  assign ex_mem_zero      = r_zero;
  assign branch_taken     = r_branch_taken;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage
//  Purpose  : Directed, table-driven bench for ex_stage: ALU functions,
//             forwarding priority, stall / flush / reset interaction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  logic                  clk = 1'b0;
  logic                  rst, stall, flush;
  logic                  id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [3:0]            id_alu_ctrl;
  logic [DATA_W-1:0]     id_rs_data, id_rt_data, id_imm, wb_result;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd, wb_rd;
  logic                  wb_reg_write;
  logic                  ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
  logic                  ex_mem_zero, branch_taken;
  logic [DATA_W-1:0]     ex_mem_result, ex_mem_store;
  logic [REG_ADDR_W-1:0] ex_mem_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_mem_valid(ex_mem_valid), .ex_mem_result(ex_mem_result),
    .ex_mem_store(ex_mem_store), .ex_mem_rd(ex_mem_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_zero(ex_mem_zero),
    .branch_taken(branch_taken)
  );

  typedef struct {
    string       nm;
    logic [3:0]  ctrl;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, imm;
    logic        src;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, v;
    logic [31:0] er, es;
    logic        ez, ebt;
  } vec_t;

  function automatic vec_t mk(string nm, logic [3:0] ctrl, logic [4:0] rs, logic [4:0] rt,
                              logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm, logic src,
                              logic [4:0] rd, logic rw, logic mr, logic mw, logic br, logic v,
                              logic [31:0] er, logic [31:0] es, logic ez, logic ebt);
    vec_t t;
    t.nm = nm; t.ctrl = ctrl; t.rs = rs; t.rt = rt; t.rsd = rsd; t.rtd = rtd;
    t.imm = imm; t.src = src; t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw;
    t.br = br; t.v = v; t.er = er; t.es = es; t.ez = ez; t.ebt = ebt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t t);
    id_alu_ctrl = t.ctrl; id_rs = t.rs; id_rt = t.rt; id_rs_data = t.rsd;
    id_rt_data = t.rtd; id_imm = t.imm; id_alu_src = t.src; id_rd = t.rd;
    id_reg_write = t.rw; id_mem_read = t.mr; id_mem_write = t.mw;
    id_branch = t.br; id_valid = t.v;
  endtask

  task automatic run(input vec_t t);
    apply(t);
    step();
    chk({t.nm, ".result"}, ex_mem_result, t.er);
    chk({t.nm, ".store"},  ex_mem_store,  t.es);
    chk({t.nm, ".zero"},   32'(ex_mem_zero), 32'(t.ez));
    chk({t.nm, ".btaken"}, 32'(branch_taken), 32'(t.ebt));
    chk({t.nm, ".valid"},  32'(ex_mem_valid), 32'(t.v));
    chk({t.nm, ".rd"},     32'(ex_mem_rd), 32'(t.rd));
    chk({t.nm, ".rw"},     32'(ex_mem_reg_write), 32'(t.v & t.rw));
    chk({t.nm, ".mr"},     32'(ex_mem_mem_read), 32'(t.v & t.mr));
    chk({t.nm, ".mw"},     32'(ex_mem_mem_write), 32'(t.v & t.mw));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".valid"},  32'(ex_mem_valid), 32'd0);
    chk({nm, ".result"}, ex_mem_result, 32'd0);
    chk({nm, ".store"},  ex_mem_store, 32'd0);
    chk({nm, ".rd"},     32'(ex_mem_rd), 32'd0);
    chk({nm, ".rw"},     32'(ex_mem_reg_write), 32'd0);
    chk({nm, ".mr"},     32'(ex_mem_mem_read), 32'd0);
    chk({nm, ".mw"},     32'(ex_mem_mem_write), 32'd0);
    chk({nm, ".zero"},   32'(ex_mem_zero), 32'd0);
    chk({nm, ".btaken"}, 32'(branch_taken), 32'd0);
  endtask

  vec_t tbl[$];
  vec_t t;

  initial begin
    // ctrl rs rt rsd rtd imm src rd rw mr mw br v | result store zero btaken
    tbl.push_back(mk("add",    4'h0, 1, 2, 32'd7, 32'd5, 32'd0, 0, 10, 1, 0, 0, 0, 1, 32'd12, 32'd5, 0, 0));
    tbl.push_back(mk("sub",    4'h1, 1, 2, 32'd7, 32'd5, 32'd0, 0, 10, 1, 0, 0, 0, 1, 32'd2, 32'd5, 0, 0));
    tbl.push_back(mk("sltneg", 4'h4, 1, 2, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 10, 1, 0, 0, 0, 1, 32'd1, 32'd1, 0, 0));
    tbl.push_back(mk("sltpos", 4'h4, 1, 2, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 10, 1, 0, 0, 0, 1, 32'd0, 32'hFFFFFFFF, 1, 0));
    tbl.push_back(mk("and",    4'h2, 1, 2, 32'hF0F0, 32'h0FF0, 32'd0, 0, 10, 1, 0, 0, 0, 1, 32'h00F0, 32'h0FF0, 0, 0));
    tbl.push_back(mk("or",     4'h3, 1, 2, 32'hF000, 32'h000F, 32'd0, 0, 10, 1, 0, 0, 0, 1, 32'hF00F, 32'h000F, 0, 0));
    tbl.push_back(mk("addi",   4'h0, 1, 2, 32'd100, 32'd555, 32'hFFFFFFFC, 1, 10, 1, 0, 0, 0, 1, 32'd96, 32'd555, 0, 0));
    tbl.push_back(mk("beqeq",  4'h1, 1, 2, 32'h1234, 32'h1234, 32'd0, 0, 0, 0, 0, 0, 1, 1, 32'd0, 32'h1234, 1, 1));
    tbl.push_back(mk("beqne",  4'h1, 1, 2, 32'h1234, 32'h1235, 32'd0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 32'h1235, 0, 0));
    tbl.push_back(mk("wrap",   4'h0, 1, 2, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 10, 1, 0, 0, 0, 1, 32'd0, 32'd1, 1, 0));
    tbl.push_back(mk("sw",     4'h0, 1, 2, 32'h1000, 32'hABCD, 32'd8, 1, 0, 0, 0, 1, 0, 1, 32'h1008, 32'hABCD, 0, 0));
    tbl.push_back(mk("lw",     4'h0, 1, 2, 32'h2000, 32'd0, 32'd4, 1, 10, 1, 1, 0, 0, 1, 32'h2004, 32'd0, 0, 0));
    tbl.push_back(mk("inv5",   4'h5, 1, 2, 32'd3, 32'd4, 32'd0, 0, 10, 1, 0, 0, 0, 1, 32'd0, 32'd4, 1, 0));
    tbl.push_back(mk("invF",   4'hF, 1, 2, 32'd3, 32'd4, 32'd0, 0, 10, 1, 0, 0, 0, 1, 32'd0, 32'd4, 1, 0));
    tbl.push_back(mk("bubble", 4'h1, 1, 2, 32'h55, 32'h55, 32'd0, 0, 10, 1, 1, 1, 1, 0, 32'd0, 32'h55, 1, 0));

    // Reset with random inputs
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    wb_reg_write = 1'($urandom); wb_rd = 5'($urandom); wb_result = $urandom;
    t = mk("rnd", 4'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
           1'($urandom), 5'($urandom), 1, 1, 1, 1, 1, 0, 0, 0, 0);
    apply(t);
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;

    foreach (tbl[i]) run(tbl[i]);

    // Back-to-back RAW: producer r3, consumer reads stale r3 = 0
    run(mk("raw_p", 4'h0, 1, 2, 32'd7, 32'd5, 32'd0, 0, 3, 1, 0, 0, 0, 1, 32'd12, 32'd5, 0, 0));
    run(mk("raw_c", 4'h1, 3, 1, 32'd0, 32'd2, 32'd0, 0, 4, 1, 0, 0, 0, 1, 32'd10, 32'd2, 0, 0));
    // r4 pending in both EX/MEM (10) and WB (99): EX/MEM wins
    wb_reg_write = 1'b1; wb_rd = 5'd4; wb_result = 32'd99;
    run(mk("pri",   4'h0, 4, 5, 32'd0, 32'd1, 32'd0, 0, 6, 1, 0, 0, 0, 1, 32'd11, 32'd1, 0, 0));
    // rs from WB (40), store data rt from EX/MEM r6 (11)
    wb_rd = 5'd7; wb_result = 32'd40;
    run(mk("wbfwd", 4'h0, 7, 6, 32'd0, 32'd0, 32'd4, 1, 0, 0, 0, 1, 0, 1, 32'd44, 32'd11, 0, 0));
    // Register 0 is never forwarded from either source
    wb_rd = 5'd0; wb_result = 32'd77;
    run(mk("rd0_p", 4'h0, 1, 2, 32'd3, 32'd4, 32'd0, 0, 0, 1, 0, 0, 0, 1, 32'd7, 32'd4, 0, 0));
    run(mk("rd0_c", 4'h0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 5, 1, 0, 0, 0, 1, 32'd0, 32'd0, 1, 0));
    // No forwarding out of a pending load in EX/MEM
    wb_reg_write = 1'b0;
    run(mk("ld_p",  4'h0, 1, 2, 32'd100, 32'd0, 32'd0, 1, 9, 1, 1, 0, 0, 1, 32'd100, 32'd0, 0, 0));
    run(mk("ld_c",  4'h0, 9, 2, 32'd5, 32'd1, 32'd0, 0, 8, 1, 0, 0, 0, 1, 32'd6, 32'd1, 0, 0));

    // Stall three cycles with changing inputs: EX/MEM holds {r8 = 6}
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(mk("junk", 4'(k), 5'(k + 1), 5'(k + 2), $urandom, $urandom, $urandom, 0,
               5'(20 + k), 1, 0, 1, 1, 1, 0, 0, 0, 0));
      step();
      chk($sformatf("stall%0d.result", k), ex_mem_result, 32'd6);
      chk($sformatf("stall%0d.rd", k), 32'(ex_mem_rd), 32'd8);
      chk($sformatf("stall%0d.valid", k), 32'(ex_mem_valid), 32'd1);
      chk($sformatf("stall%0d.mw", k), 32'(ex_mem_mem_write), 32'd0);
      chk($sformatf("stall%0d.store", k), ex_mem_store, 32'd1);
    end
    stall = 1'b0;
    run(mk("post_stall", 4'h0, 8, 0, 32'd0, 32'd0, 32'd0, 0, 11, 1, 0, 0, 0, 1, 32'd6, 32'd0, 0, 0));

    // Flush with stall: flush wins, controls drop, data held
    stall = 1'b1; flush = 1'b1;
    apply(mk("fl", 4'h0, 1, 2, 32'd50, 32'd50, 32'd0, 0, 13, 1, 1, 1, 1, 1, 0, 0, 0, 0));
    step();
    chk("flst.valid",  32'(ex_mem_valid), 32'd0);
    chk("flst.rw",     32'(ex_mem_reg_write), 32'd0);
    chk("flst.result", ex_mem_result, 32'd6);
    chk("flst.rd",     32'(ex_mem_rd), 32'd11);
    stall = 1'b0; flush = 1'b0;
    // Flushed r11 must no longer forward
    run(mk("post_flush", 4'h0, 11, 0, 32'd3, 32'd0, 32'd0, 0, 12, 1, 0, 0, 0, 1, 32'd3, 32'd0, 0, 0));

    // Flush alone on a taken branch / store
    flush = 1'b1;
    apply(mk("flb", 4'h1, 1, 2, 32'h1234, 32'h1234, 32'd0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0));
    step();
    chk("flush.btaken", 32'(branch_taken), 32'd0);
    chk("flush.mw",     32'(ex_mem_mem_write), 32'd0);
    chk("flush.mr",     32'(ex_mem_mem_read), 32'd0);
    chk("flush.valid",  32'(ex_mem_valid), 32'd0);
    flush = 1'b0;

    // Reset during stall: bubble, then stall keeps the bubble
    run(mk("pre_rst", 4'h0, 1, 2, 32'd1, 32'd2, 32'd0, 0, 14, 1, 0, 0, 0, 1, 32'd3, 32'd2, 0, 0));
    stall = 1'b1; rst = 1'b1;
    step();
    chk_all_zero("rst_stall");
    rst = 1'b0;
    step();
    chk("rst_stall_hold.valid", 32'(ex_mem_valid), 32'd0);
    chk("rst_stall_hold.rw",    32'(ex_mem_reg_write), 32'd0);
    stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
